stage_if: RTL and testbench
===========================

# stage_if

Stage 1 (IF) of the 5-level MIPS pipeline: the upstream end of the IF/ID interface consumed by the decode stage. It owns the fetch PC and issues one-outstanding-request reads to instruction memory, which may take a variable number of cycles to answer. It presents `pc4_id`/`instr_id` to ID and obeys ID's `stall`. It applies ID's `pc_select` redirects with exactly one architectural delay slot.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset_0`  in  1  reset, synchronous, active-high
- `pc_select`  in  2  from ID: 00 sequential, 01 branch (`pc_b`), 10 jr (`a_id`), 11 j/jal (`pc_j`)
- `pc_b`  in  32  branch target from ID
- `pc_j`  in  32  jump target from ID
- `a_id`  in  32  forwarded rs value from ID (jr target)
- `stall`  in  1  ID holds its instruction; IF/ID register must not change
- `im_req`  out  1  instruction-memory request
- `im_addr`  out  32  word address of the request (bits [1:0] = 0)
- `im_ack`  in  1  memory response valid; may assert in the same cycle as `im_req`
- `im_data`  in  32  instruction word, valid with `im_ack`
- `pc4_id`  out  32  fetch address + 4 of the instruction in ID
- `instr_id`  out  32  instruction in ID; 32'h0 (NOP) when empty
- `valid_id`  out  1  `instr_id` holds a real instruction

## Operation
- Registers: `pc_fetch` (32), IF/ID register {`valid_id`, `instr_id`, `pc4_id`}, one-entry skid {valid, instr, pc4}, redirect-pending {valid, target}.
- FSM states: REQ and HOLD.
- REQ: `im_req`=1 and `im_addr`=`pc_fetch`; both are held stable until `im_ack`.
- On `im_ack` in REQ:
  - If ID accepts (`!stall | !valid_id`), load the IF/ID register with {1, `im_data`, `pc_fetch`+4} and stay in REQ.
  - Otherwise write the response to the skid and go to HOLD.
- HOLD: `im_req`=0. When ID accepts, move the skid into IF/ID, clear the skid, and go to REQ.
- ID accepts and nothing arrives (no ack, skid empty): IF/ID loads {0, 32'h0, `pc4_id`}, i.e. a bubble.
- `stall`=1 with `valid_id`=1: the IF/ID register holds all bits.
- Redirect is accepted when `valid_id & !stall & pc_select!=00`. The target is selected per `pc_select`.
- The instruction fetched after the branch (the delay slot) is always delivered.
- Redirect-accept cycle:
  - If no request is outstanding (HOLD), or `im_ack` is high this cycle, set `pc_fetch` ← target.
  - Otherwise set pending ← {1, target}.
- On any `im_ack`: `pc_fetch` ← pending.valid ? pending.target : `pc_fetch`+4, and pending is cleared.
- `pc_select` is ignored when `!valid_id` or `stall`.
- Arithmetic: 32-bit, wraps modulo 2^32. `pc_fetch`[1:0] is forced to 00. No alignment exception.

## Timing
- Reset values: `pc_fetch`=`RESET_PC`, `valid_id`=0, `instr_id`=0, `pc4_id`=0, skid and pending invalid, `im_req`=0 during reset, state=REQ.
- `im_req` rises in the first cycle after `reset_0` deasserts.
- Latency: `im_ack` in cycle n gives `instr_id`/`valid_id` in cycle n+1 when not stalled.
- Zero-wait memory sustains 1 instruction/cycle.
- Stall during an ack: the instruction reaches ID one cycle after `stall` drops. No new request is issued while the skid is full.
- Reset mid-request drops `im_req`. The memory must abandon the request; `im_ack` is ignored whenever `im_req`=0.
- A redirect and an ack in the same cycle update `pc_fetch` directly, with no pending entry.

## Structure
- Shared package holds:
  - `pc_select` encodings: `PCSEL_SEQ`, `PCSEL_BR`, `PCSEL_JR`, `PCSEL_J`
  - `NOP_INSTR` = 32'h0
  - FSM state encodings
- Sub-module `if_skid`: one-entry holding register with load/unload/clear. `stage_if` instantiates it once.

## Test plan
- Reset with `RESET_PC`=0 and 0-wait memory returning addr-based words: `im_addr` sequence 0,4,8,…; `pc4_id` = 4,8,12,… on consecutive cycles; `valid_id`=1 from cycle 2.
- 3-cycle memory latency: `valid_id` pattern 1,0,0,1 repeating; no address is skipped or duplicated.
- `stall` held for 4 cycles while an ack for 0x10 arrives: IF/ID frozen, `im_req`=0 in HOLD. After release, `pc4_id`=0x14 and then fetching resumes at 0x14.
- beq in ID at `pc4_id`=0x24 with `pc_select`=01, `pc_b`=0x100, while the 0x24 fetch is outstanding: the delay slot from 0x24 is delivered, the next `im_addr`=0x100, and 0x28 is never requested.
- jr with `pc_select`=10, `a_id`=0x2000 on the same cycle as an ack: the next `im_addr`=0x2000 and pending stays clear.
- `reset_0` asserted mid-wait: outputs return to their reset values, the late `im_ack` is ignored, and refetch starts at `RESET_PC`.

Source files
------------

// File: rtl/stage_if_pkg.sv
// Shared definitions for the IF stage: pc_select encodings, the NOP word,
// FSM state encoding and the redirect-target helper.
package stage_if_pkg;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JR  = 2'b10;
  localparam logic [1:0] PCSEL_J   = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    StReq  = 1'b0,
    StHold = 1'b1
  } if_state_e;

  // Word-aligned next-fetch target for a given pc_select encoding.
  function automatic logic [31:0] pc_target(input logic [1:0]  sel,
                                            input logic [31:0] pc_seq,
                                            input logic [31:0] pc_b,
                                            input logic [31:0] a_id,
                                            input logic [31:0] pc_j);
    logic [31:0] t;
    case (sel)
      PCSEL_BR: t = pc_b;
      PCSEL_JR: t = a_id;
      PCSEL_J:  t = pc_j;
      default:  t = pc_seq;
    endcase
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_if_skid.sv
// One-entry holding register for an instruction word that arrived while ID
// was stalled. Load has priority over unload; clear empties it synchronously.
module if_skid
  import stage_if_pkg::*;
(
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc4_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/stage_if.sv
// MIPS IF stage: owns the fetch PC, issues one-outstanding instruction reads,
// feeds the IF/ID register and applies ID redirects after one delay slot.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_0,
  input  logic [1:0]  pc_select,
  input  logic [31:0] pc_b,
  input  logic [31:0] pc_j,
  input  logic [31:0] a_id,
  input  logic        stall,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_data,
  output logic [31:0] pc4_id,
  output logic [31:0] instr_id,
  output logic        valid_id
);

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  if_state_e   state_q, state_d;
  logic [31:0] pc_fetch_q, pc_fetch_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic        ack;
  logic        accept;
  logic        redirect;
  logic [31:0] pc_seq;
  logic [31:0] target;
  logic        skid_load, skid_unload, skid_valid;
  logic [31:0] skid_instr, skid_pc4;

  // A response only counts while a request is actually being driven.
  assign ack      = im_req & im_ack;
  assign accept   = !stall || !valid_q;
  assign redirect = valid_q && !stall && (pc_select != PCSEL_SEQ);
  assign pc_seq   = pc_fetch_q + 32'd4;
  assign target   = pc_target(pc_select, pc_seq, pc_b, a_id, pc_j);

  assign skid_load   = (state_q == StReq) && ack && !accept;
  assign skid_unload = (state_q == StHold) && accept;

  if_skid u_skid (
    .clk_i    (clock),
    .clear_i  (reset_0),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .instr_i  (im_data),
    .pc4_i    (pc_seq),
    .valid_o  (skid_valid),
    .instr_o  (skid_instr),
    .pc4_o    (skid_pc4)
  );

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset_0) begin
      state_q <= StReq;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StReq:   if (ack && !accept) state_d = StHold;
      StHold:  if (accept) state_d = StReq;
      default: state_d = StReq;
    endcase
  end

  // FSM: outputs; reset drops the request combinationally so memory abandons it
  always_comb begin
    im_req = 1'b0;
    case (state_q)
      StReq:   im_req = !reset_0;
      default: im_req = 1'b0;
    endcase
  end

  // IF/ID register next state
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (accept) begin
      if (state_q == StHold) begin
        valid_d = skid_valid;
        instr_d = skid_instr;
        pc4_d   = skid_pc4;
      end else if (ack) begin
        valid_d = 1'b1;
        instr_d = im_data;
        pc4_d   = pc_seq;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        pc4_d   = pc4_q;
      end
    end
  end

  // Fetch PC and pending redirect. A redirect that cannot land now (delay-slot
  // fetch still outstanding) parks in pending and is consumed by the next ack.
  always_comb begin
    pc_fetch_d    = pc_fetch_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (ack) begin
      pc_fetch_d   = pend_valid_q ? pend_target_q : pc_seq;
      pend_valid_d = 1'b0;
    end
    if (redirect) begin
      if ((state_q == StHold) || ack) begin
        pc_fetch_d   = target;
        pend_valid_d = 1'b0;
      end else begin
        pend_valid_d  = 1'b1;
        pend_target_d = target;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_0) begin
      pc_fetch_q    <= ResetPcAligned;
      valid_q       <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc4_q         <= 32'h0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      pc_fetch_q    <= {pc_fetch_d[31:2], 2'b00};
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      pc4_q         <= pc4_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign im_addr  = pc_fetch_q;
  assign valid_id = valid_q;
  assign instr_id = instr_q;
  assign pc4_id   = pc4_q;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: a per-cycle vector table with a zero-wait
// memory, then a 3-cycle-latency memory sequence.
module tb_stage_if;

  logic        clock;
  logic        reset_0;
  logic [1:0]  pc_select;
  logic [31:0] pc_b, pc_j, a_id;
  logic        stall;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_data;
  logic [31:0] pc4_id, instr_id;
  logic        valid_id;

  int checks   = 0;
  int failures = 0;

  stage_if dut (
    .clock     (clock),
    .reset_0   (reset_0),
    .pc_select (pc_select),
    .pc_b      (pc_b),
    .pc_j      (pc_j),
    .a_id      (a_id),
    .stall     (stall),
    .im_req    (im_req),
    .im_addr   (im_addr),
    .im_ack    (im_ack),
    .im_data   (im_data),
    .pc4_id    (pc4_id),
    .instr_id  (instr_id),
    .valid_id  (valid_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        stl;
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  localparam int NumVec = 22;
  localparam logic [31:0] Junk = 32'hDEAD_BEEF;
  vec_t tbl [NumVec];

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic vec_t mk(input logic rst, input logic stl, input logic [1:0] sel,
                              input logic [31:0] tgt, input logic ack, input logic [31:0] data,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4);
    vec_t v;
    v.rst = rst; v.stl = stl; v.sel = sel; v.tgt = tgt; v.ack = ack; v.data = data;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc4 = e_pc4;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Non-selected targets carry distinct junk so a wrong mux leg shows up.
  task automatic drive(input vec_t v);
    reset_0   = v.rst;
    stall     = v.stl;
    pc_select = v.sel;
    pc_b      = (v.sel == 2'b01) ? v.tgt : 32'hBAD0_0010;
    a_id      = (v.sel == 2'b10) ? v.tgt : 32'hBAD0_0020;
    pc_j      = (v.sel == 2'b11) ? v.tgt : 32'hBAD0_0030;
    im_ack    = v.ack;
    im_data   = v.data;
  endtask

  initial begin
    int          wait_cnt;
    logic        prev_ack;
    logic [31:0] exp_addr, exp_pc4;

    reset_0 = 1'b1; stall = 1'b0; pc_select = 2'b00;
    pc_b = '0; pc_j = '0; a_id = '0; im_ack = 1'b0; im_data = '0;

    //          rst stl sel tgt       ack data          req addr      vld instr         pc4
    tbl[0]  = mk(1, 0, 0, 0,         0, 0,             0, 32'h0,     0, 0,             32'h0);
    tbl[1]  = mk(0, 0, 0, 0,         1, w(32'h0),      1, 32'h0,     0, 0,             32'h0);
    tbl[2]  = mk(0, 0, 0, 0,         1, w(32'h4),      1, 32'h4,     1, w(32'h0),      32'h4);
    tbl[3]  = mk(0, 0, 0, 0,         1, w(32'h8),      1, 32'h8,     1, w(32'h4),      32'h8);
    tbl[4]  = mk(0, 1, 0, 0,         1, w(32'hC),      1, 32'hC,     1, w(32'h8),      32'hC);
    tbl[5]  = mk(0, 1, 0, 0,         1, Junk,          0, 32'h10,    1, w(32'h8),      32'hC);
    tbl[6]  = mk(0, 0, 0, 0,         1, Junk,          0, 32'h10,    1, w(32'h8),      32'hC);
    tbl[7]  = mk(0, 0, 0, 0,         1, w(32'h10),     1, 32'h10,    1, w(32'hC),      32'h10);
    tbl[8]  = mk(0, 0, 0, 0,         0, 0,             1, 32'h14,    1, w(32'h10),     32'h14);
    tbl[9]  = mk(0, 0, 0, 0,         0, 0,             1, 32'h14,    0, 0,             32'h14);
    tbl[10] = mk(0, 0, 0, 0,         1, w(32'h14),     1, 32'h14,    0, 0,             32'h14);
    tbl[11] = mk(0, 0, 2, 32'h2000,  1, w(32'h18),     1, 32'h18,    1, w(32'h14),     32'h18);
    tbl[12] = mk(0, 0, 0, 0,         0, 0,             1, 32'h2000,  1, w(32'h18),     32'h1C);
    tbl[13] = mk(0, 0, 3, 32'h3000,  1, w(32'h2000),   1, 32'h2000,  0, 0,             32'h1C);
    tbl[14] = mk(0, 1, 3, 32'h3000,  1, w(32'h2004),   1, 32'h2004,  1, w(32'h2000),   32'h2004);
    tbl[15] = mk(0, 0, 3, 32'h3000,  0, 0,             0, 32'h2008,  1, w(32'h2000),   32'h2004);
    tbl[16] = mk(0, 0, 1, 32'h101,   0, 0,             1, 32'h3000,  1, w(32'h2004),   32'h2008);
    tbl[17] = mk(0, 0, 1, 32'h101,   1, w(32'h3000),   1, 32'h3000,  0, 0,             32'h2008);
    tbl[18] = mk(0, 0, 0, 0,         1, w(32'h100),    1, 32'h100,   1, w(32'h3000),   32'h3004);
    tbl[19] = mk(0, 0, 0, 0,         0, 0,             1, 32'h104,   1, w(32'h100),    32'h104);
    tbl[20] = mk(1, 0, 0, 0,         1, Junk,          0, 32'h104,   0, 0,             32'h104);
    tbl[21] = mk(0, 0, 0, 0,         0, 0,             1, 32'h0,     0, 0,             32'h0);

    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < NumVec; i++) begin
      drive(tbl[i]);
      #4;
      check($sformatf("row%0d.im_req", i),   {31'b0, im_req},   {31'b0, tbl[i].e_req});
      check($sformatf("row%0d.im_addr", i),  im_addr,           tbl[i].e_addr);
      check($sformatf("row%0d.valid_id", i), {31'b0, valid_id}, {31'b0, tbl[i].e_valid});
      check($sformatf("row%0d.instr_id", i), instr_id,          tbl[i].e_instr);
      check($sformatf("row%0d.pc4_id", i),   pc4_id,            tbl[i].e_pc4);
      @(posedge clock);
      #1;
    end

    // 3-cycle memory: ack on the third cycle of each request.
    reset_0 = 1'b1; stall = 1'b0; pc_select = 2'b00; im_ack = 1'b0;
    @(posedge clock);
    #1;
    reset_0  = 1'b0;
    #1;
    wait_cnt = 0;
    prev_ack = 1'b0;
    exp_addr = 32'h0;
    exp_pc4  = 32'h4;
    for (int c = 0; c < 15; c++) begin
      check($sformatf("lat%0d.valid_id", c), {31'b0, valid_id}, {31'b0, prev_ack});
      if (prev_ack) begin
        check($sformatf("lat%0d.pc4_id", c), pc4_id, exp_pc4);
        check($sformatf("lat%0d.instr_id", c), instr_id, w(exp_pc4 - 32'd4));
        exp_pc4 = exp_pc4 + 32'd4;
      end
      check($sformatf("lat%0d.im_req", c), {31'b0, im_req}, 32'd1);
      check($sformatf("lat%0d.im_addr", c), im_addr, exp_addr);
      im_ack  = (wait_cnt == 2);
      im_data = w(im_addr);
      prev_ack = im_ack;
      if (im_ack) begin
        exp_addr = exp_addr + 32'd4;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
      @(posedge clock);
      #2;
    end
    im_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
